// File: rtl/pong_pkg.sv
// Shared Pong definitions: default screen/ball/racket geometry and the
// ball state machine encoding used by the ball, racket and renderer stages.
package pong_pkg;

    localparam int unsigned PONG_SCREEN_W  = 640;
    localparam int unsigned PONG_SCREEN_H  = 480;
    localparam int unsigned PONG_BALL_SIZE = 8;
    localparam int unsigned PONG_RACKET_X  = 16;
    localparam int unsigned PONG_RACKET_W  = 8;
    localparam int unsigned PONG_RACKET_H  = 64;
    localparam int unsigned PONG_POS_W     = 10;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_WAIT,
        PLAY
    } ball_state_t;

    // Top-left coordinate that centres an object of 'size' within 'span'.
    function automatic int unsigned pong_centre(input int unsigned span,
                                                input int unsigned size);
        return (span - size) / 2;
    endfunction

endpackage

// File: rtl/pong_tick.sv
// Free-running divider: count runs 0..TICK_DIV-1 and tick is high in the
// cycle where count is at its last value.
module pong_tick #(
    parameter  int unsigned TICK_DIV = 4,
    localparam int unsigned CNT_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic             tick,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign tick  = (count_q == LAST);
    assign count = count_q;

    // Wrap to zero after the tick cycle, otherwise advance.
    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (tick) begin
            count_d = '0;
        end
    end

    // Counter register, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ball_motion.sv
// Ball position and collision engine: serve/play state machine, one pixel
// per axis per tick, reflections off top/bottom/right walls and the racket,
// hit/miss event pulses and a saturating hit counter.
module ball_motion
    import pong_pkg::*;
#(
    parameter int unsigned SCREEN_W    = PONG_SCREEN_W,
    parameter int unsigned SCREEN_H    = PONG_SCREEN_H,
    parameter int unsigned BALL_SIZE   = PONG_BALL_SIZE,
    parameter int unsigned RACKET_X    = PONG_RACKET_X,
    parameter int unsigned RACKET_W    = PONG_RACKET_W,
    parameter int unsigned RACKET_H    = PONG_RACKET_H,
    parameter int unsigned TICK_DIV    = 416667,
    parameter int unsigned SERVE_DELAY = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] racket_y,
    input  logic       serve,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       active,
    output logic       hit,
    output logic       miss,
    output logic [7:0] hit_count
);

    localparam int unsigned WAIT_W   = $clog2(SERVE_DELAY + 1);
    localparam int unsigned TCNT_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [9:0]  X_MAX    = 10'(SCREEN_W - BALL_SIZE);
    localparam logic [9:0]  Y_MAX    = 10'(SCREEN_H - BALL_SIZE);
    localparam logic [9:0]  X_CENTRE = 10'(pong_centre(SCREEN_W, BALL_SIZE));
    localparam logic [9:0]  Y_CENTRE = 10'(pong_centre(SCREEN_H, BALL_SIZE));
    localparam logic [9:0]  X_RACKET = 10'(RACKET_X + RACKET_W);

    ball_state_t       state_q, state_d;
    logic [9:0]        x_q, x_d;
    logic [9:0]        y_q, y_d;
    logic              dx_q, dx_d;      // 1: moving right
    logic              dy_q, dy_d;      // 1: moving down
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [7:0]        hit_count_q, hit_count_d;
    logic              hit_q, hit_d;
    logic              miss_q, miss_d;

    logic              tick;
    logic [TCNT_W-1:0] unused_tick_count;

    logic              hit_top, hit_bottom, hit_right, hit_racket, at_miss;
    logic [10:0]       ball_bot, racket_bot;

    pong_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .count (unused_tick_count)
    );

    // 11-bit sums keep racket_y + RACKET_H from wrapping.
    assign ball_bot   = {1'b0, y_q} + 11'(BALL_SIZE);
    assign racket_bot = {1'b0, racket_y} + 11'(RACKET_H);

    assign hit_top    = !dy_q && (y_q == '0);
    assign hit_bottom =  dy_q && (y_q == Y_MAX);
    assign hit_right  =  dx_q && (x_q == X_MAX);
    assign at_miss    = !dx_q && (x_q == '0);
    assign hit_racket = !dx_q && (x_q == X_RACKET)
                        && (ball_bot > {1'b0, racket_y})
                        && ({1'b0, y_q} < racket_bot);

    assign ball_x    = x_q;
    assign ball_y    = y_q;
    assign active    = (state_q == PLAY);
    assign hit       = hit_q;
    assign miss      = miss_q;
    assign hit_count = hit_count_q;

    // Next-state, direction and position logic for serve/wait/play.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        wait_d      = wait_q;
        hit_count_d = hit_count_q;
        hit_d       = 1'b0;
        miss_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (serve) begin
                    state_d     = SERVE_WAIT;
                    hit_count_d = '0;
                    dx_d        = 1'b1;
                    wait_d      = WAIT_W'(SERVE_DELAY);
                end
            end
            SERVE_WAIT: begin
                if (tick) begin
                    if (wait_q == WAIT_W'(1)) begin
                        state_d = PLAY;
                    end
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            PLAY: begin
                if (tick) begin
                    if (at_miss) begin
                        miss_d  = 1'b1;
                        x_d     = X_CENTRE;
                        y_d     = Y_CENTRE;
                        state_d = IDLE;
                    end else begin
                        // All flips land first so the step uses the new directions.
                        if (hit_top)    dy_d = 1'b1;
                        if (hit_bottom) dy_d = 1'b0;
                        if (hit_right)  dx_d = 1'b0;
                        if (hit_racket) begin
                            dx_d  = 1'b1;
                            hit_d = 1'b1;
                            if (hit_count_q != 8'hFF) begin
                                hit_count_d = hit_count_q + 8'd1;
                            end
                        end
                        x_d = dx_d ? (x_q + 10'd1) : (x_q - 10'd1);
                        y_d = dy_d ? (y_q + 10'd1) : (y_q - 10'd1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, position and event registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            x_q         <= X_CENTRE;
            y_q         <= Y_CENTRE;
            dx_q        <= 1'b1;
            dy_q        <= 1'b1;
            wait_q      <= '0;
            hit_count_q <= '0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            wait_q      <= wait_d;
            hit_count_q <= hit_count_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
        end
    end

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion with TICK_DIV=4, SERVE_DELAY=2. A second
// instance with a square field (640x640) reaches a corner from the serve.
module tb_ball_motion;

    localparam int unsigned TICK_DIV    = 4;
    localparam int unsigned SERVE_DELAY = 2;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       serve    = 1'b0;
    logic       serve_sq = 1'b0;
    logic [9:0] racket_y = '0;
    logic [9:0] ball_x, ball_y, sq_x, sq_y;
    logic       active, hit, miss, sq_active, sq_hit, sq_miss;
    logic [7:0] hit_count, sq_hit_count;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    ball_motion #(
        .TICK_DIV    (TICK_DIV),
        .SERVE_DELAY (SERVE_DELAY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .racket_y  (racket_y),
        .serve     (serve),
        .ball_x    (ball_x),
        .ball_y    (ball_y),
        .active    (active),
        .hit       (hit),
        .miss      (miss),
        .hit_count (hit_count)
    );

    ball_motion #(
        .SCREEN_H    (640),
        .TICK_DIV    (TICK_DIV),
        .SERVE_DELAY (SERVE_DELAY)
    ) dut_sq (
        .clk       (clk),
        .reset     (reset),
        .racket_y  (10'd0),
        .serve     (serve_sq),
        .ball_x    (sq_x),
        .ball_y    (sq_y),
        .active    (sq_active),
        .hit       (sq_hit),
        .miss      (sq_miss),
        .hit_count (sq_hit_count)
    );

    task automatic check_eq(input string tag, input int unsigned obs,
                            input int unsigned exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Wait for the next position update; returns cycles taken.
    task automatic next_move(output int unsigned cyc);
        logic [9:0] px, py;
        logic       moved;
        px  = ball_x;
        py  = ball_y;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (ball_x == px && ball_y == py && cyc < 12);
        moved = (ball_x != px) || (ball_y != py);
        check_eq("moved", moved, 1);
    endtask

    task automatic wait_x(input int unsigned tx);
        int unsigned n = 0;
        while (ball_x != tx && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check_eq("reach_x", ball_x, tx);
    endtask

    task automatic wait_active();
        int unsigned n = 0;
        while (!active && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("serve_active", active, 1);
    endtask

    task automatic pulse_serve();
        serve = 1'b1;
        @(negedge clk);
        serve = 1'b0;
    endtask

    initial begin
        int unsigned cyc;
        int unsigned lat;

        // Reset state
        #23;
        check_eq("rst_x", ball_x, 316);
        check_eq("rst_y", ball_y, 236);
        check_eq("rst_active", active, 0);
        check_eq("rst_hit_count", hit_count, 0);
        check_eq("rst_hit", hit, 0);
        check_eq("rst_miss", miss, 0);
        check_eq("rst_sq_y", sq_y, 316);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Serve both instances on the same edge
        serve    = 1'b1;
        serve_sq = 1'b1;
        @(negedge clk);
        serve    = 1'b0;
        serve_sq = 1'b0;
        lat = 0;
        while (!active && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_eq("serve_latency_in_5_8", (lat >= 5 && lat <= 8), 1);
        check_eq("play_x", ball_x, 316);

        next_move(cyc);
        check_eq("step1_x", ball_x, 317);
        check_eq("step1_y", ball_y, 237);
        next_move(cyc);
        check_eq("step_period", cyc, 4);
        check_eq("step2_x", ball_x, 318);

        // Serve ignored during PLAY
        pulse_serve();
        check_eq("reserve_active", active, 1);
        next_move(cyc);
        check_eq("reserve_x", ball_x, 319);
        check_eq("reserve_y", ball_y, 239);

        // Bottom wall
        wait_x(552);
        check_eq("bottom_y", ball_y, 472);
        next_move(cyc);
        check_eq("bottom_next_x", ball_x, 553);
        check_eq("bottom_next_y", ball_y, 471);

        // Right wall; square instance hits its corner on the same tick
        wait_x(632);
        check_eq("right_y", ball_y, 392);
        check_eq("corner_x", sq_x, 632);
        check_eq("corner_y", sq_y, 632);
        next_move(cyc);
        check_eq("right_next_x", ball_x, 631);
        check_eq("right_next_y", ball_y, 391);
        check_eq("corner_next_x", sq_x, 631);
        check_eq("corner_next_y", sq_y, 631);
        check_eq("corner_active", sq_active, 1);
        check_eq("corner_no_hit", sq_hit, 0);
        check_eq("corner_no_miss", sq_miss, 0);
        check_eq("corner_hit_count", sq_hit_count, 0);

        // Racket hit, racket_y = ball_y - 10
        racket_y = 10'd206;
        wait_x(24);
        check_eq("hit1_y", ball_y, 216);
        next_move(cyc);
        check_eq("hit1_pulse", hit, 1);
        check_eq("hit1_count", hit_count, 1);
        check_eq("hit1_x", ball_x, 25);
        check_eq("hit1_y_next", ball_y, 217);
        @(negedge clk);
        check_eq("hit1_pulse_end", hit, 0);

        // Top-edge overlap by one pixel: hit
        wait_x(24);
        check_eq("hit2_y", ball_y, 456);
        racket_y = ball_y + 10'd7;
        next_move(cyc);
        check_eq("hit2_pulse", hit, 1);
        check_eq("hit2_count", hit_count, 2);
        check_eq("hit2_x", ball_x, 25);
        check_eq("hit2_y_next", ball_y, 455);
        @(negedge clk);
        check_eq("hit2_pulse_end", hit, 0);

        // Racket bottom exactly at ball top: no hit, then miss
        wait_x(24);
        check_eq("nohit1_y", ball_y, 184);
        racket_y = ball_y - 10'd64;
        next_move(cyc);
        check_eq("nohit1_pulse", hit, 0);
        check_eq("nohit1_count", hit_count, 2);
        check_eq("nohit1_x", ball_x, 23);
        wait_x(0);
        check_eq("miss1_y", ball_y, 160);
        next_move(cyc);
        check_eq("miss1_pulse", miss, 1);
        check_eq("miss1_active", active, 0);
        check_eq("miss1_x", ball_x, 316);
        check_eq("miss1_y_ctr", ball_y, 236);
        check_eq("miss1_count_kept", hit_count, 2);
        @(negedge clk);
        check_eq("miss1_pulse_end", miss, 0);
        repeat (8) @(negedge clk);
        check_eq("idle_hold_x", ball_x, 316);

        // Second rally
        pulse_serve();
        check_eq("reserve_clear_count", hit_count, 0);
        wait_active();
        wait_x(24);
        check_eq("hit3_y", ball_y, 256);
        racket_y = ball_y - 10'd63;
        next_move(cyc);
        check_eq("hit3_pulse", hit, 1);
        check_eq("hit3_count", hit_count, 1);
        check_eq("hit3_x", ball_x, 25);
        check_eq("hit3_y_next", ball_y, 255);

        // Racket top exactly at ball bottom: no hit
        wait_x(24);
        check_eq("nohit2_y", ball_y, 16);
        racket_y = ball_y + 10'd8;
        next_move(cyc);
        check_eq("nohit2_pulse", hit, 0);
        check_eq("nohit2_x", ball_x, 23);
        check_eq("nohit2_y_next", ball_y, 17);
        racket_y = 10'd400;
        wait_x(0);
        check_eq("miss2_y", ball_y, 40);
        next_move(cyc);
        check_eq("miss2_pulse", miss, 1);
        check_eq("miss2_active", active, 0);
        check_eq("miss2_x", ball_x, 316);
        check_eq("miss2_count_kept", hit_count, 1);

        // Asynchronous reset during PLAY
        pulse_serve();
        wait_active();
        next_move(cyc);
        check_eq("pre_areset_x", ball_x, 317);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check_eq("areset_x", ball_x, 316);
        check_eq("areset_y", ball_y, 236);
        check_eq("areset_active", active, 0);
        check_eq("areset_hit_count", hit_count, 0);
        @(negedge clk);
        reset = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
